// File: rtl/decode_hazard_ctrl_pkg.sv
// Shared decode-stage definitions: controller state encodings, scoreboard
// depth and the scoreboard entry layout.
package decode_hazard_ctrl_pkg;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // Scoreboard slots in flight behind ID: EX, MEM, WB.
  localparam int SB_DEPTH = 3;
  localparam int SB_EX    = 0;
  localparam int SB_MEM   = 1;
  localparam int SB_WB    = 2;

  typedef struct packed {
    logic       valid;
    logic [2:0] dest;
  } sb_entry_t;

endpackage

// File: rtl/decode_hazard_ctrl_if.sv
// ID-stage request bundle and pipeline-control responses of the decode
// hazard controller. master = ID stage side, slave = controller side.
interface decode_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [2:0]       id_rs;
  logic [2:0]       id_rt;
  logic             id_rs_used;
  logic             id_rt_used;
  logic             id_reg_write;
  logic [2:0]       id_dest;
  logic             id_halt;
  logic             ex_redirect;
  logic             stall_if;
  logic             stall_id;
  logic             bubble_ex;
  logic             flush_ifid;
  logic             halted;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_reg_write, id_dest, id_halt, ex_redirect,
    input  stall_if, stall_id, bubble_ex, flush_ifid, halted, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_reg_write, id_dest, id_halt, ex_redirect,
    output stall_if, stall_id, bubble_ex, flush_ifid, halted, stall_count
  );
endinterface

// File: rtl/decode_hazard_ctrl_sb_match.sv
// Compares one source register select against the EX and MEM scoreboard
// entries. WB is deliberately excluded: the register file writes before it
// reads, so a WB producer is already visible to ID.
module sb_match
  import decode_hazard_ctrl_pkg::*;
(
  input  logic [2:0] src_i,
  input  sb_entry_t  ex_i,
  input  sb_entry_t  mem_i,
  output logic       match_o
);

  // A pending producer in EX or MEM writing this source
  always_comb begin
    match_o = (ex_i.valid  && (ex_i.dest  == src_i)) ||
              (mem_i.valid && (mem_i.dest == src_i));
  end

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage hazard controller: RAW interlock against a 3-deep write
// scoreboard, EX redirect flush, HALT drain sequencing and a saturating
// stall-cycle counter.
module decode_hazard_ctrl
  import decode_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
)(
  input  logic                 clk,
  input  logic                 rst,
  decode_hazard_ctrl_if.slave  bus
);

  logic [1:0]       state_q, state_d;
  logic             sb_vld_q  [SB_DEPTH];
  logic [2:0]       sb_dest_q [SB_DEPTH];
  sb_entry_t        sb_ex, sb_mem;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             rs_match, rt_match, hazard, issue, sb_write;
  logic             stall_if, stall_id, bubble_ex, flush_ifid, halted;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign sb_ex  = '{valid: sb_vld_q[SB_EX],  dest: sb_dest_q[SB_EX]};
  assign sb_mem = '{valid: sb_vld_q[SB_MEM], dest: sb_dest_q[SB_MEM]};

  sb_match u_rs_match (
    .src_i   (bus.id_rs),
    .ex_i    (sb_ex),
    .mem_i   (sb_mem),
    .match_o (rs_match)
  );

  sb_match u_rt_match (
    .src_i   (bus.id_rt),
    .ex_i    (sb_ex),
    .mem_i   (sb_mem),
    .match_o (rt_match)
  );

  // RAW hazard only for sources the instruction actually reads
  always_comb begin
    hazard = bus.id_valid &&
             ((bus.id_rs_used && rs_match) || (bus.id_rt_used && rt_match));
  end

  // Control decode: redirect beats hazard and HALT; DRAIN/HALTED freeze the front end
  always_comb begin
    state_d       = state_q;
    stall_count_d = stall_count_q;
    issue         = 1'b0;
    stall_if      = 1'b0;
    stall_id      = 1'b0;
    bubble_ex     = 1'b0;
    flush_ifid    = 1'b0;
    halted        = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.ex_redirect) begin
          flush_ifid = 1'b1;
          bubble_ex  = 1'b1;
        end else if (hazard) begin
          stall_if      = 1'b1;
          stall_id      = 1'b1;
          bubble_ex     = 1'b1;
          stall_count_d = sat_inc(stall_count_q);
        end else begin
          issue = bus.id_valid;
          if (issue && bus.id_halt) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus.ex_redirect) begin
          flush_ifid = 1'b1;
          bubble_ex  = 1'b1;
        end else begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
        end
        if (!sb_vld_q[SB_EX] && !sb_vld_q[SB_MEM] && !sb_vld_q[SB_WB])
          state_d = ST_HALTED;
      end
      ST_HALTED: begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
        halted    = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // HALT never claims a destination even if its write flag is set
  assign sb_write = issue && bus.id_reg_write && !bus.id_halt;

  // Controller state and stall counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Scoreboard valid bits shift EX -> MEM -> WB every cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SB_DEPTH; i++) sb_vld_q[i] <= 1'b0;
    end else begin
      sb_vld_q[SB_EX] <= sb_write;
      for (int i = 1; i < SB_DEPTH; i++) sb_vld_q[i] <= sb_vld_q[i-1];
    end
  end

  // Scoreboard destinations follow the valid bits; meaningful only when valid
  always_ff @(posedge clk) begin
    sb_dest_q[SB_EX] <= bus.id_dest;
    for (int i = 1; i < SB_DEPTH; i++) sb_dest_q[i] <= sb_dest_q[i-1];
  end

  assign bus.stall_if    = stall_if;
  assign bus.stall_id    = stall_id;
  assign bus.bubble_ex   = bubble_ex;
  assign bus.flush_ifid  = flush_ifid;
  assign bus.halted      = halted;
  assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Bench for decode_hazard_ctrl: directed hazard/redirect/halt/reset scenarios
// followed by random traffic against a queue-based reference model.
module tb_decode_hazard_ctrl;

  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  decode_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  decode_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: dest history of the last three issue slots (-1 = none),
  // mode 0 running, 1 draining after HALT, 2 halted.
  int sb[$];
  int m_mode;
  int m_cnt;
  int e_cnt_next;
  bit e_sif, e_sid, e_bub, e_flush, e_halted, e_issue;
  logic o_stall_id;
  logic o_halted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    sb = '{-1, -1, -1};
    m_mode = 0;
    m_cnt = 0;
  endfunction

  function automatic void model_eval();
    bit haz;
    int rs, rt;
    rs = int'(bus.id_rs);
    rt = int'(bus.id_rt);
    haz = bus.id_valid &&
          ((bus.id_rs_used && (rs == sb[0] || rs == sb[1])) ||
           (bus.id_rt_used && (rt == sb[0] || rt == sb[1])));
    {e_sif, e_sid, e_bub, e_flush, e_halted, e_issue} = '0;
    e_cnt_next = m_cnt;
    if (m_mode == 2) begin
      {e_sif, e_sid, e_bub, e_halted} = 4'b1111;
    end else if (bus.ex_redirect) begin
      {e_flush, e_bub} = 2'b11;
    end else if (m_mode == 1) begin
      {e_sif, e_sid, e_bub} = 3'b111;
    end else if (haz) begin
      {e_sif, e_sid, e_bub} = 3'b111;
      e_cnt_next = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    end else begin
      e_issue = bus.id_valid;
    end
  endfunction

  function automatic void model_clock();
    bool_drained_check();
    if (m_mode == 0 && e_issue && bus.id_halt) m_mode = 1;
    sb.push_front((e_issue && bus.id_reg_write && !bus.id_halt) ? int'(bus.id_dest) : -1);
    void'(sb.pop_back());
    m_cnt = e_cnt_next;
  endfunction

  function automatic void bool_drained_check();
    if (m_mode == 1 && sb[0] < 0 && sb[1] < 0 && sb[2] < 0) m_mode = 2;
  endfunction

  task automatic check_now(input string tag);
    model_eval();
    o_stall_id = bus.stall_id;
    o_halted   = bus.halted;
    chk({tag, ".stall_if"},    32'(bus.stall_if),    32'(e_sif));
    chk({tag, ".stall_id"},    32'(bus.stall_id),    32'(e_sid));
    chk({tag, ".bubble_ex"},   32'(bus.bubble_ex),   32'(e_bub));
    chk({tag, ".flush_ifid"},  32'(bus.flush_ifid),  32'(e_flush));
    chk({tag, ".halted"},      32'(bus.halted),      32'(e_halted));
    chk({tag, ".stall_count"}, 32'(bus.stall_count), 32'(m_cnt));
  endtask

  // Called just after a rising edge; applies inputs for one full cycle.
  task automatic cycle(input string tag, input bit v, input int rs, input bit rsu,
                       input int rt, input bit rtu, input bit wr, input int dest,
                       input bit halt, input bit redir);
    bus.id_valid     = v;
    bus.id_rs        = 3'(rs);
    bus.id_rs_used   = rsu;
    bus.id_rt        = 3'(rt);
    bus.id_rt_used   = rtu;
    bus.id_reg_write = wr;
    bus.id_dest      = 3'(dest);
    bus.id_halt      = halt;
    bus.ex_redirect  = redir;
    #4;
    check_now(tag);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle(input string tag);
    cycle(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Holds an instruction in ID until the controller stops stalling it.
  task automatic send(input string tag, input int rs, input bit rsu, input bit wr,
                      input int dest, output int stalls);
    stalls = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(tag, 1, rs, rsu, 0, 0, wr, dest, 0, 0);
      if (o_stall_id !== 1'b1) return;
      stalls++;
    end
    chk({tag, ".timeout"}, 32'(stalls), 32'd0);
  endtask

  // Asynchronous reset mid-cycle, released away from the clock edge.
  task automatic do_reset(input string tag);
    bus.id_valid = 0; bus.id_rs_used = 0; bus.id_rt_used = 0;
    bus.id_reg_write = 0; bus.id_halt = 0; bus.ex_redirect = 0;
    rst = 1'b0;
    #2;
    model_reset();
    check_now(tag);
    #4;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int st;
    logic hseen [1:4];
    checks = 0;
    errors = 0;
    bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_rs_used = 0;
    bus.id_rt_used = 0; bus.id_reg_write = 0; bus.id_dest = 0;
    bus.id_halt = 0; bus.ex_redirect = 0;
    rst = 1'b0;
    #2;
    model_reset();
    check_now("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back dependency: 2 stall cycles
    send("b2b_wr", 0, 0, 1, 1, st);
    send("b2b_rd", 1, 1, 0, 0, st);
    chk("b2b_stalls", 32'(st), 32'd2);
    chk("b2b_count", 32'(bus.stall_count), 32'd2);

    // One instruction between: 1 stall; WB-only distance: none
    send("gap_wr", 0, 0, 1, 2, st);
    send("gap_mid", 6, 1, 0, 0, st);
    send("gap_rd", 2, 1, 0, 0, st);
    chk("gap_stalls", 32'(st), 32'd1);
    send("wb_wr", 0, 0, 1, 4, st);
    idle("wb_nop1");
    idle("wb_nop2");
    send("wb_rd", 4, 1, 0, 0, st);
    chk("wb_stalls", 32'(st), 32'd0);
    chk("wb_count", 32'(bus.stall_count), 32'd3);

    // Hazard and redirect together: flush wins, nothing enters EX
    send("rdr_wr", 0, 0, 1, 5, st);
    cycle("rdr_hit", 1, 5, 1, 0, 0, 1, 6, 0, 1);
    chk("rdr_count", 32'(bus.stall_count), 32'd3);
    send("rdr_after", 6, 1, 0, 0, st);
    chk("rdr_ex_empty", 32'(st), 32'd0);

    // Drive the counter into saturation
    for (int i = 0; i < 8; i++) begin
      send("sat_wr", 0, 0, 1, 1, st);
      send("sat_rd", 1, 1, 0, 0, st);
    end
    chk("sat_full", 32'(bus.stall_count), 32'(CNT_MAX));
    send("sat_wr2", 0, 0, 1, 1, st);
    send("sat_rd2", 1, 1, 0, 0, st);
    chk("sat_hold", 32'(bus.stall_count), 32'(CNT_MAX));

    // HALT behind a writer to R3: 3 drain cycles, halted on the 4th
    send("halt_wr", 0, 0, 1, 3, st);
    cycle("halt_issue", 1, 0, 0, 0, 0, 1, 3, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      idle("halt_drain");
      hseen[k] = o_halted;
    end
    chk("halt_d1", 32'(hseen[1]), 32'd0);
    chk("halt_d3", 32'(hseen[3]), 32'd0);
    chk("halt_on", 32'(hseen[4]), 32'd1);
    cycle("halt_redir", 1, 0, 0, 0, 0, 0, 0, 0, 1);
    idle("halt_stay");
    chk("halt_stay1", 32'(o_halted), 32'd1);

    // Reset out of HALTED, then reset in the middle of DRAIN
    do_reset("rst_halted");
    send("drn_wr", 0, 0, 1, 3, st);
    cycle("drn_halt", 1, 0, 0, 0, 0, 0, 0, 1, 0);
    idle("drn_mid");
    do_reset("rst_drain");
    send("drn_rd", 3, 1, 0, 0, st);
    chk("drn_nostall", 32'(st), 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ((m_mode == 2 && $urandom_range(3, 0) == 0) || $urandom_range(149, 0) == 0) begin
        do_reset("rnd_reset");
      end else begin
        cycle("rnd",
              $urandom_range(9, 0) != 0,
              $urandom_range(3, 0), $urandom_range(1, 0),
              $urandom_range(3, 0), $urandom_range(1, 0),
              $urandom_range(1, 0), $urandom_range(3, 0),
              $urandom_range(39, 0) == 0,
              $urandom_range(7, 0) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
